// File: rtl/piso_stream_serializer.sv
// Parallel-in / serial-out feeder for the serial pattern detector.
// One-word holding buffer lets consecutive words stream with no idle bit slots.
module piso_stream_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  input  logic             load_i,
  output logic             ready_o,
  input  logic             pause_i,
  output logic             d_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             word_done_o
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             xfer;
  logic             last_bit;
  logic [WIDTH-1:0] shift_next;

  // Handshake: a word is taken on any edge with load_i=1 and ready_o=1.
  // ready_o depends only on the registered buffer flag, so upstream never
  // sees a combinational path from load_i back to ready_o.
  assign ready_o     = ~hold_full_q;
  assign accept      = load_i & ready_o;

  assign busy_o      = (state_q == ST_SHIFT);
  assign valid_o     = busy_o & ~pause_i;
  assign xfer        = valid_o;
  assign last_bit    = (cnt_q == LAST);
  assign word_done_o = xfer & last_bit;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign d_o        = shift_q[0];
      assign shift_next = {1'b0, shift_q[WIDTH-1:1]};
    end else begin : g_msb_first
      assign d_o        = shift_q[WIDTH-1];
      assign shift_next = {shift_q[WIDTH-2:0], 1'b0};
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        // The buffer is always empty here; accepted words go straight to the shifter.
        if (accept) begin
          shift_d = data_i;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (xfer && last_bit) begin
          if (hold_full_q) begin
            shift_d     = hold_q;
            cnt_d       = '0;
            hold_full_d = 1'b0;
          end else if (accept) begin
            shift_d = data_i;
            cnt_d   = '0;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end else begin
          if (xfer) begin
            shift_d = shift_next;
            cnt_d   = cnt_q + 1'b1;
          end
          if (accept) begin
            hold_d      = data_i;
            hold_full_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: doc/piso_stream_serializer.md
Name: piso_stream_serializer

Overview:
- Upstream feeder for the serial pattern detector stage.
- Accepts parallel words over a valid/ready handshake and emits them one bit per clock on a serial data/valid pair that connects directly to the detector's d_i/valid_i.
- Has a one-word holding buffer, so consecutive words stream with no idle bit slots.
- Has a pause input to insert gaps in the bit stream.

Parameters:
- WIDTH, 8, parallel word width in bits; legal range WIDTH >= 2.
- LSB_FIRST, 0, 0 = shift out MSB first; 1 = shift out LSB first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- data_i  input  WIDTH  parallel word; sampled on handshake.
- load_i  input  1  upstream valid for data_i.
- ready_o  output  1  block can accept a word this cycle.
- pause_i  input  1  stall request; blocks bit transfers while high.
- d_o  output  1  serial data bit; connects to detector d_i.
- valid_o  output  1  d_o holds a valid bit; connects to detector valid_i.
- busy_o  output  1  shifter holds a word that is not yet fully transferred.
- word_done_o  output  1  last bit of a word transfers at this edge.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge clk.
  - Reset is asynchronous, active-low. While rst=0: shifter, holding buffer, bit counter and state are cleared.
  - Output values during reset: ready_o=1, d_o=0, valid_o=0, busy_o=0, word_done_o=0.
- Handshake:
  - A word is accepted on an edge where load_i=1 and ready_o=1.
  - ready_o is registered: ready_o = holding buffer empty.
  - data_i must not be sampled when ready_o=0, and an unaccepted word is never lost from the upstream side.
- Bit transfer:
  - A bit transfers on every rising edge where valid_o=1.
  - valid_o = busy_o AND NOT pause_i. This is the only combinational path from an input, pause_i, to outputs valid_o and word_done_o.
  - d_o is driven from the registered shifter: the MSB when LSB_FIRST=0, the LSB when LSB_FIRST=1. d_o is stable whenever valid_o=1.
- States:
  - IDLE (busy_o=0). An accepted word loads directly into the shifter and the counter is set to 0. The next cycle has busy_o=1 and the first bit on d_o. Latency is 1 cycle from the accepting edge to the first valid bit.
  - SHIFT (busy_o=1).
    - On a transfer edge with counter < WIDTH-1: shift by one toward the output end and increment the counter.
    - On a transfer edge with counter = WIDTH-1 (last bit):
      - if the holding buffer is full, move it into the shifter, reset the counter, and clear the holding buffer;
      - else if a word is accepted on this same edge, load it straight into the shifter;
      - else go to IDLE.
    - With no gaps, bit slots of consecutive words are contiguous.
    - An edge where pause_i=1 changes no shifter or counter state; d_o holds its value.
    - A word accepted while in SHIFT goes to the holding buffer; ready_o=0 from the next cycle.
- word_done_o = valid_o AND (counter = WIDTH-1).
- Counter is clog2(WIDTH) bits wide and never exceeds WIDTH-1.
- Boundary cases:
  - Holding buffer full: load_i is ignored. ready_o rises in the cycle after the buffer drains into the shifter.
  - Accept and last-bit transfer on the same edge:
    - holding buffer empty → direct load into the shifter (no gap);
    - holding buffer full → not possible, because ready_o=0.
  - pause_i during IDLE has no effect. load_i is still accepted.
  - pause_i held on the last bit: word_done_o stays 0 until pause_i drops.
  - Reset asserted mid-word: the partial word and the held word are discarded, and valid_o drops to 0 immediately (asynchronously). There is no partial-word resume after reset is released.

Test Plan:
1. Single word, MSB first: WIDTH=8, LSB_FIRST=0, data_i=8'hB5 loaded from IDLE, pause_i=0 → d_o sequence 1,0,1,1,0,1,0,1 across 8 consecutive cycles. valid_o=1 for exactly 8 cycles, word_done_o=1 on the 8th cycle only, then busy_o=0 and ready_o=1.
2. Back-to-back words: 8'hB5, then 8'h0F accepted during the first word's bit 2 → 16 contiguous valid_o cycles with bits 10110101 00001111. ready_o=0 from the accept until the last bit of 8'hB5, and ready_o=1 one cycle after that. word_done_o pulses at cycles 8 and 16.
3. Backpressure: with the holding buffer full, present 8'hAA with load_i=1 → not accepted while ready_o=0. Accepted on the first edge with ready_o=1, and appears as the third word with no bit lost or duplicated.
4. Pause: pause_i=1 for 3 cycles after bit 4 of 8'hB5 → valid_o=0 for those 3 cycles, d_o holds the same bit, and the transfer resumes with the remaining bits 0,1,0,1. Total latency is 11 cycles.
5. Reset mid-word: assert rst=0 after 3 bits of 8'hB5 with 8'h0F held → valid_o=0, busy_o=0 and ready_o=1 immediately. After release, no bits are emitted until a new load.
6. LSB_FIRST=1, data_i=8'hB5 → d_o sequence 1,0,1,0,1,1,0,1.
7. Integration: feed 75 random words (600 bits, seed 124) into the pattern detector → the detector's pattern-hit count equals the count from a bit-level reference model.
